// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused across WIDTH bits, LSB first.
// Optional subtract mode (sub_i port) enabled by defining BIT_SERIAL_ADD_CTRL_SUB_EN.
module bit_serial_add_ctrl #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef BIT_SERIAL_ADD_CTRL_SUB_EN
    input  logic             sub_i,
`endif
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;

    logic               sub_c;
    logic               bit_c;
    logic               carry_c;

`ifdef BIT_SERIAL_ADD_CTRL_SUB_EN
    assign sub_c = sub_i;
`else
    assign sub_c = 1'b0;
`endif

    // The shared one-bit adder cell.
    assign bit_c   = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = sub_c ? ~b_i : b_i;
                    carry_d = sub_c;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {bit_c, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_c;
                // Result is published on the last bit so it is already valid during DONE.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = {bit_c, res_q[WIDTH-1:1]};
                    cout_d  = carry_c;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q == RUN);
    assign done_o  = done_q;
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed self-checking bench for bit_serial_add_ctrl (WIDTH=8), including
// the subtract cases when BIT_SERIAL_ADD_CTRL_SUB_EN is defined.
module tb_bit_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
`ifdef BIT_SERIAL_ADD_CTRL_SUB_EN
    logic             sub_i;
`endif
    logic             ready_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;

    int checks = 0;
    int errors = 0;

    bit_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
`ifdef BIT_SERIAL_ADD_CTRL_SUB_EN
        .sub_i   (sub_i),
`endif
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .cout_o  (cout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept an op, then check busy/done timing cycle by cycle and the final result.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        check("ready_before_op", 32'(ready_o), 32'd1);
        a_i     = a;
        b_i     = b;
`ifdef BIT_SERIAL_ADD_CTRL_SUB_EN
        sub_i   = sub;
`else
        if (sub) $display("note: subtract requested without subtract support");
`endif
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        a_i     = ~a;
        b_i     = ~b;
        for (int i = 0; i < WIDTH; i++) begin
            check($sformatf("busy_run%0d", i), 32'({busy_o, done_o, ready_o}), 32'b100);
            step();
        end
        check("done_pulse", 32'({busy_o, done_o, ready_o}), 32'b010);
        check("sum", 32'(sum_o), 32'(exp_sum));
        check("cout", 32'(cout_o), 32'(exp_cout));
        step();
        check("after_done", 32'({busy_o, done_o, ready_o}), 32'b001);
        check("sum_hold", 32'(sum_o), 32'(exp_sum));
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b1;
        a_i     = 8'h12;
        b_i     = 8'h34;
`ifdef BIT_SERIAL_ADD_CTRL_SUB_EN
        sub_i   = 1'b0;
`endif
        step();
        step();
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_sum", 32'(sum_o), 32'h00);
        check("rst_cout", 32'(cout_o), 32'd0);
        start_i = 1'b0;
        rst     = 1'b0;
        step();
        check("idle_after_rst", 32'({busy_o, done_o, ready_o}), 32'b001);

        // Basic adds and wrap-around.
        run_op(8'h35, 8'h1C, 1'b0, 8'h51, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        run_op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

        // Start while busy or in DONE is ignored; result then holds.
        a_i = 8'h0F; b_i = 8'h01; start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 1; i <= WIDTH; i++) begin
            a_i = 8'hAA; b_i = 8'h55;
            start_i = (i == 2);
            step();
        end
        start_i = 1'b1;
        check("rej_done", 32'(done_o), 32'd1);
        check("rej_sum", 32'(sum_o), 32'h10);
        check("rej_cout", 32'(cout_o), 32'd0);
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rej_idle%0d", i), 32'({busy_o, done_o, ready_o}), 32'b001);
            check($sformatf("rej_hold%0d", i), 32'(sum_o), 32'h10);
            step();
        end

        // Reset in the middle of an op: no done, state back to reset values.
        a_i = 8'hF0; b_i = 8'h0F; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step(); step(); step();
        check("mid_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        start_i = 1'b1;
        step();
        rst = 1'b0;
        start_i = 1'b0;
        check("mid_rst_state", 32'({busy_o, done_o, ready_o}), 32'b001);
        check("mid_rst_sum", 32'(sum_o), 32'h00);
        check("mid_rst_cout", 32'(cout_o), 32'd0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            check($sformatf("mid_no_done%0d", i), 32'(done_o), 32'd0);
            step();
        end
        run_op(8'h02, 8'h03, 1'b0, 8'h05, 1'b0);

`ifdef BIT_SERIAL_ADD_CTRL_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        run_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
        run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
